// File: rtl/usb3_rx_pkg.sv
// Purpose: shared state encoding and K-symbol constants for the USB 3.0 RX lock controller.
// Latency: none (package only).
// Backpressure: none (package only).
package usb3_rx_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_HUNT    = 3'd1,
      ST_VERIFY  = 3'd2,
      ST_LOCKED  = 3'd3,
      ST_RECOVER = 3'd4
   } lock_state_e;

   localparam logic [7:0]  K_COM     = 8'hBC;
   localparam logic [7:0]  K_SKP     = 8'h3C;
   localparam logic [31:0] COM_WORD  = {4{K_COM}};
   localparam logic [3:0]  COM_DATAK = 4'hF;

endpackage

// File: rtl/usb3_rx_lock_ctrl_err_window.sv
// Purpose: counts error events inside a free-running window and trips at a threshold.
// Latency: trip is combinational on the error event that reaches the threshold.
// Backpressure: none; clear holds the window at its start and suppresses trip.
//
// Ports:
//   local_clk, reset_n : clock, synchronous active-low reset
//   clear              : hold window counter and error count at zero
//   err_evt            : one error event this cycle
//   trip               : error count reaches ERR_THRESH this cycle
module usb3_err_window #(
   parameter int unsigned ERR_THRESH = 4,
   parameter int unsigned ERR_WINDOW = 256
) (
   input  logic local_clk,
   input  logic reset_n,
   input  logic clear,
   input  logic err_evt,
   output logic trip
);

   localparam int unsigned WW = (ERR_WINDOW > 1) ? $clog2(ERR_WINDOW) : 1;
   localparam logic [WW-1:0] WIN_LAST = '1;
   localparam logic [7:0] THRESH_C = 8'(ERR_THRESH);

   logic [WW-1:0] win_cnt_q, win_cnt_d;
   logic [7:0]    win_errs_q, win_errs_d;

   always_comb begin
      win_cnt_d  = '0;
      win_errs_d = '0;
      if (!clear) begin
         // Window length is a power of two, so the counter wraps on its own.
         win_cnt_d = win_cnt_q + 1'b1;
         // On the wrap cycle the old count is dropped, but an error arriving
         // on that same cycle must not be lost: it seeds the next window.
         if (win_cnt_q == WIN_LAST) begin
            win_errs_d = {7'd0, err_evt};
         end else begin
            win_errs_d = win_errs_q + {7'd0, err_evt};
         end
      end
   end

   assign trip = !clear && err_evt && (win_errs_d == THRESH_C);

   always_ff @(posedge local_clk) begin
      if (!reset_n) begin
         win_cnt_q  <= '0;
         win_errs_q <= '0;
      end else begin
         win_cnt_q  <= win_cnt_d;
         win_errs_q <= win_errs_d;
      end
   end

endmodule

// File: rtl/usb3_rx_lock_ctrl.sv
// Purpose: sequences RX descrambler enable and ordered-set lock from the descrambled word stream.
// Latency: all outputs registered, one cycle after the deciding input sample.
// Backpressure: none; inactive proc_active cycles freeze word counting.
//
// Ports:
//   local_clk, reset_n       : clock, synchronous active-low reset
//   enable, scram_allow      : LTSSM run request, scrambling permitted
//   proc_active/datak/data   : descrambled word stream
//   err_skp_unexpected       : sticky SKP error (rising edge counts once)
//   rx_err                   : per-cycle decode error
//   ds_enable, rx_locked, lock_lost, lock_state, err_count : status outputs
module usb3_rx_lock_ctrl
   import usb3_rx_pkg::*;
#(
   parameter int unsigned LOCK_OS      = 8,
   parameter int unsigned OS_WORDS     = 4,
   parameter int unsigned ERR_THRESH   = 4,
   parameter int unsigned ERR_WINDOW   = 256,
   parameter int unsigned IDLE_TIMEOUT = 1024
) (
   input  logic        local_clk,
   input  logic        reset_n,
   input  logic        enable,
   input  logic        scram_allow,
   input  logic        proc_active,
   input  logic [3:0]  proc_datak,
   input  logic [31:0] proc_data,
   input  logic        err_skp_unexpected,
   input  logic        rx_err,
   output logic        ds_enable,
   output logic        rx_locked,
   output logic        lock_lost,
   output logic [2:0]  lock_state,
   output logic [7:0]  err_count
);

   localparam int unsigned WW = (OS_WORDS > 1) ? $clog2(OS_WORDS) : 1;
   localparam int unsigned IW = $clog2(IDLE_TIMEOUT + 1);
   localparam logic [WW-1:0] WCNT_LAST = WW'(OS_WORDS - 1);
   localparam logic [IW-1:0] IDLE_LIM  = IW'(IDLE_TIMEOUT);
   localparam logic [7:0]    LOCK_OS_C = 8'(LOCK_OS);

   lock_state_e   state_q, state_d;
   logic [WW-1:0] wcnt_q, wcnt_d;
   logic [7:0]    os_cnt_q, os_cnt_d;
   logic [IW-1:0] idle_cnt_q, idle_cnt_d;
   logic [7:0]    err_count_q, err_count_d;
   logic          skp_q;
   logic          ds_enable_q, rx_locked_q, lock_lost_q;
   logic [2:0]    lock_state_q;

   logic com_word, err_evt, win_trip;

   assign com_word = proc_active && (proc_datak == COM_DATAK) && (proc_data == COM_WORD);
   assign err_evt  = rx_err || (err_skp_unexpected && !skp_q);

   usb3_err_window #(
      .ERR_THRESH (ERR_THRESH),
      .ERR_WINDOW (ERR_WINDOW)
   ) u_err_window (
      .local_clk (local_clk),
      .reset_n   (reset_n),
      .clear     (state_q != ST_LOCKED),
      .err_evt   (err_evt),
      .trip      (win_trip)
   );

   always_comb begin
      state_d     = state_q;
      wcnt_d      = wcnt_q;
      os_cnt_d    = os_cnt_q;
      idle_cnt_d  = '0;
      err_count_d = err_count_q;
      if (!enable) begin
         state_d     = ST_IDLE;
         wcnt_d      = '0;
         os_cnt_d    = '0;
         err_count_d = '0;
      end else begin
         case (state_q)
            ST_IDLE: state_d = ST_HUNT;
            ST_HUNT: begin
               if (com_word) begin
                  state_d  = ST_VERIFY;
                  os_cnt_d = 8'd1;
                  wcnt_d   = '0;
               end
            end
            ST_VERIFY: begin
               if (err_evt) begin
                  state_d = ST_HUNT;
               end else if (proc_active) begin
                  if (com_word) begin
                     wcnt_d = '0;
                     if (wcnt_q == WCNT_LAST) begin
                        os_cnt_d = os_cnt_q + 8'd1;
                        if (os_cnt_d == LOCK_OS_C) state_d = ST_LOCKED;
                     end else begin
                        // Early COM: treat it as the first set of a new candidate.
                        os_cnt_d = 8'd1;
                     end
                  end else if (wcnt_q == WCNT_LAST) begin
                     state_d = ST_HUNT;
                  end else begin
                     wcnt_d = wcnt_q + 1'b1;
                  end
               end
            end
            ST_LOCKED: begin
               if (err_evt && (err_count_q != 8'hFF)) err_count_d = err_count_q + 8'd1;
               idle_cnt_d = proc_active ? '0 : idle_cnt_q + 1'b1;
               if (win_trip || (idle_cnt_d == IDLE_LIM)) state_d = ST_RECOVER;
            end
            ST_RECOVER: begin
               state_d  = ST_HUNT;
               wcnt_d   = '0;
               os_cnt_d = '0;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge local_clk) begin
      if (!reset_n) begin
         state_q      <= ST_IDLE;
         wcnt_q       <= '0;
         os_cnt_q     <= '0;
         idle_cnt_q   <= '0;
         err_count_q  <= '0;
         skp_q        <= 1'b0;
         ds_enable_q  <= 1'b0;
         rx_locked_q  <= 1'b0;
         lock_lost_q  <= 1'b0;
         lock_state_q <= 3'd0;
      end else begin
         state_q      <= state_d;
         wcnt_q       <= wcnt_d;
         os_cnt_q     <= os_cnt_d;
         idle_cnt_q   <= idle_cnt_d;
         err_count_q  <= err_count_d;
         skp_q        <= err_skp_unexpected;
         // Decoded from the next state so ds_enable tracks state with no extra lag.
         ds_enable_q  <= enable && scram_allow && (state_d != ST_IDLE) && (state_d != ST_RECOVER);
         rx_locked_q  <= (state_d == ST_LOCKED);
         lock_lost_q  <= (state_d == ST_RECOVER);
         lock_state_q <= state_d;
      end
   end

   assign ds_enable  = ds_enable_q;
   assign rx_locked  = rx_locked_q;
   assign lock_lost  = lock_lost_q;
   assign lock_state = lock_state_q;
   assign err_count  = err_count_q;

endmodule

// File: tb/tb_usb3_rx_lock_ctrl.sv
module tb_usb3_rx_lock_ctrl;

   localparam int LOCK_OS = 8, OS_WORDS = 4, ERR_THRESH = 4, ERR_WINDOW = 256, IDLE_TIMEOUT = 1024;

   logic        local_clk = 1'b0;
   logic        reset_n = 1'b0, enable = 1'b0, scram_allow = 1'b0;
   logic        proc_active = 1'b0, err_skp_unexpected = 1'b0, rx_err = 1'b0;
   logic [3:0]  proc_datak = 4'h0;
   logic [31:0] proc_data = 32'h0;
   logic        ds_enable, rx_locked, lock_lost;
   logic [2:0]  lock_state;
   logic [7:0]  err_count;

   usb3_rx_lock_ctrl dut (
      .local_clk(local_clk), .reset_n(reset_n), .enable(enable), .scram_allow(scram_allow),
      .proc_active(proc_active), .proc_datak(proc_datak), .proc_data(proc_data),
      .err_skp_unexpected(err_skp_unexpected), .rx_err(rx_err),
      .ds_enable(ds_enable), .rx_locked(rx_locked), .lock_lost(lock_lost),
      .lock_state(lock_state), .err_count(err_count)
   );

   always #4 local_clk = ~local_clk;

   typedef struct packed {
      logic       ds;
      logic       lk;
      logic       ll;
      logic [2:0] st;
      logic [7:0] ec;
   } exp_t;

   exp_t exp_q[$];
   int n_chk = 0, n_fail = 0, out_idx = 0;

   // Reference model: phase names 0..4 as listed for lock_state.
   int m_phase = 0, m_since = 0, m_os = 0, m_idle = 0, m_ec = 0;
   int m_lockcyc = 0, m_win_idx = 0, m_win_n = 0;
   bit m_skp_prev = 0;

   task automatic model_step();
      bit   com, evt, trip;
      int   nxt, widx;
      exp_t e;
      if (!reset_n) begin
         m_phase = 0; m_since = 0; m_os = 0; m_idle = 0; m_ec = 0; m_skp_prev = 0;
         exp_q.push_back('0);
         return;
      end
      com = proc_active && proc_datak == 4'hF && proc_data == 32'hBCBCBCBC;
      evt = rx_err || (err_skp_unexpected && !m_skp_prev);
      m_skp_prev = err_skp_unexpected;
      nxt = m_phase;
      if (!enable) begin
         nxt = 0;
         m_ec = 0;
      end else begin
         case (m_phase)
            0: nxt = 1;
            1: if (com) begin nxt = 2; m_os = 1; m_since = 0; end
            2: begin
               if (evt) nxt = 1;
               else if (proc_active) begin
                  if (com) begin
                     if (m_since == OS_WORDS - 1) begin
                        m_os++;
                        if (m_os == LOCK_OS) nxt = 3;
                     end else m_os = 1;
                     m_since = 0;
                  end else if (m_since == OS_WORDS - 1) nxt = 1;
                  else m_since++;
               end
            end
            3: begin
               trip = 0;
               if (evt) begin
                  if (m_ec < 255) m_ec++;
                  // An error on the last cycle of a window belongs to the next one.
                  widx = (m_lockcyc + 1) / ERR_WINDOW;
                  if (widx != m_win_idx) begin m_win_idx = widx; m_win_n = 0; end
                  m_win_n++;
                  trip = (m_win_n == ERR_THRESH);
               end
               m_idle = proc_active ? 0 : m_idle + 1;
               if (trip || m_idle == IDLE_TIMEOUT) nxt = 4;
               m_lockcyc++;
            end
            default: nxt = 1;
         endcase
      end
      if (nxt == 3 && m_phase != 3) begin
         m_lockcyc = 0; m_win_idx = 0; m_win_n = 0; m_idle = 0;
      end
      m_phase = nxt;
      e.ds = enable && scram_allow && nxt != 0 && nxt != 4;
      e.lk = (nxt == 3);
      e.ll = (nxt == 4);
      e.st = 3'(nxt);
      e.ec = 8'(m_ec);
      exp_q.push_back(e);
   endtask

   // Monitor: every clock presents a new registered output set.
   initial begin
      exp_t e, a;
      forever begin
         @(posedge local_clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {ds_enable, rx_locked, lock_lost, lock_state, err_count};
            n_chk++;
            out_idx++;
            if (a !== e)  begin
               n_fail++;
               $display("FAIL outputs@cycle%0d: got ds=%0b lk=%0b ll=%0b st=%0d ec=%0d, expected ds=%0b lk=%0b ll=%0b st=%0d ec=%0d",
                        out_idx, a.ds, a.lk, a.ll, a.st, a.ec, e.ds, e.lk, e.ll, e.st, e.ec);
            end
         end
      end
   end

   task automatic check(input string name, input int got, input int exp);
      n_chk++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   task automatic step(input bit act, input bit com, input bit rxe);
      proc_active = act;
      rx_err = rxe;
      if (com) begin
         proc_datak = 4'hF;
         proc_data  = 32'hBCBCBCBC;
      end else begin
         proc_datak = 4'($urandom_range(0, 15));
         proc_data  = $urandom;
         if (proc_data == 32'hBCBCBCBC) proc_data = 32'h0;
      end
      model_step();
      @(negedge local_clk);
   endtask

   // One ordered-set frame: COM then ndata words, with optional idle gaps.
   // Gap cycles sometimes carry the COM pattern, which must be ignored.
   task automatic frame(input int ndata, input int gap_pct);
      if ($urandom_range(0, 99) < gap_pct) step(0, $urandom_range(0, 1) == 1, 0);
      step(1, 1, 0);
      for (int k = 0; k < ndata; k++) begin
         if ($urandom_range(0, 99) < gap_pct) step(0, $urandom_range(0, 1) == 1, 0);
         step(1, 0, 0);
      end
   endtask

   task automatic restart();
      enable = 0;
      step(1, 0, 0);
      step(1, 0, 0);
      enable = 1;
   endtask

   task automatic lock_up(input int gap_pct);
      step(1, 0, 0);
      for (int f = 0; f < LOCK_OS; f++) frame(OS_WORDS - 1, gap_pct);
   endtask

   initial begin
      int pos, err_div;
      bit act, com;
      @(negedge local_clk);
      reset_n = 0;
      repeat (3) step(0, 0, 0);
      check("reset_state", lock_state, 0);
      check("reset_ds_enable", ds_enable, 0);
      reset_n = 1;

      // 1: basic acquisition
      enable = 1; scram_allow = 1;
      step(1, 0, 0);
      check("ds_enable_after_enable", ds_enable, 1);
      check("hunt_state", lock_state, 1);
      step(1, 1, 0);
      check("verify_on_first_com", lock_state, 2);
      repeat (3) step(1, 0, 0);
      for (int f = 1; f < LOCK_OS; f++) frame(OS_WORDS - 1, 0);
      check("locked_after_8_com", rx_locked, 1);

      // 2: early COM restarts the candidate; missing COM returns to HUNT
      restart();
      step(1, 0, 0);
      repeat (5) frame(3, 0);
      frame(2, 0);
      repeat (7) frame(3, 0);
      check("no_lock_after_7_more", rx_locked, 0);
      frame(3, 0);
      check("lock_after_restart", rx_locked, 1);
      restart();
      step(1, 0, 0);
      repeat (3) frame(3, 0);
      repeat (4) step(1, 0, 0);
      check("missing_com_hunt", lock_state, 1);

      // 3: error burst trips, spread errors survive a wrap
      restart();
      lock_up(0);
      for (int k = 0; k < 4; k++) begin
         repeat (10) step(1, 0, 0);
         step(1, 0, 1);
      end
      check("err_burst_lock_lost", lock_lost, 1);
      check("err_burst_recover", lock_state, 4);
      check("err_burst_count", err_count, 4);
      step(1, 0, 0);
      check("recover_to_hunt", lock_state, 1);
      check("lock_lost_single", lock_lost, 0);
      restart();
      lock_up(0);
      for (int k = 0; k < 3; k++) begin repeat (20) step(1, 0, 0); step(1, 0, 1); end
      repeat (260) step(1, 0, 0);
      step(1, 0, 1);
      repeat (5) step(1, 0, 0);
      check("spread_errs_locked", rx_locked, 1);

      // 4: idle timeout boundary
      restart();
      lock_up(0);
      repeat (IDLE_TIMEOUT - 1) step(0, 0, 0);
      check("idle_1023_locked", rx_locked, 1);
      step(0, 0, 0);
      check("idle_timeout_recover", lock_state, 4);
      restart();
      lock_up(0);
      repeat (IDLE_TIMEOUT - 1) step(0, 0, 0);
      step(1, 0, 0);
      repeat (5) step(0, 0, 0);
      check("idle_then_active_locked", rx_locked, 1);

      // 5: sticky SKP error counts once; enable drop while locked
      restart();
      lock_up(0);
      err_skp_unexpected = 1;
      repeat (50) step(1, 0, 0);
      err_skp_unexpected = 0;
      check("skp_sticky_once", err_count, 1);
      enable = 0;
      step(1, 0, 0);
      check("enable_drop_idle", lock_state, 0);
      check("enable_drop_no_pulse", lock_lost, 0);
      check("enable_drop_ds", ds_enable, 0);
      check("enable_drop_ec", err_count, 0);
      enable = 1;

      // 6: scrambling disabled, gaps inside frames
      scram_allow = 0;
      lock_up(30);
      check("noscram_locked", rx_locked, 1);
      check("noscram_ds", ds_enable, 0);
      scram_allow = 1;

      // Random traffic against the model
      pos = 0; err_div = 300;
      for (int i = 0; i < 6000; i++) begin
         if (i % 500 == 0) err_div = $urandom_range(15, 400);
         if ($urandom_range(0, 999) < 2) enable = !enable;
         else if (!enable && $urandom_range(0, 19) == 0) enable = 1;
         if ($urandom_range(0, 999) < 3) scram_allow = !scram_allow;
         if ($urandom_range(0, 199) == 0) err_skp_unexpected = !err_skp_unexpected;
         act = $urandom_range(0, 9) != 0;
         com = (pos == 0) ? ($urandom_range(0, 49) != 0) : ($urandom_range(0, 199) == 0);
         if (act) pos = (pos + 1) % OS_WORDS;
         step(act, com, $urandom_range(0, err_div) == 0);
      end

      enable = 0;
      repeat (3) step(0, 0, 0);
      @(negedge local_clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
